lab2_sseg_drv: RTL and testbench

LAB2_SSEG_DRV -- requirements
Module: lab2_sseg_drv

---
 rtl/lab2_pkg.sv | 34 +++
 rtl/lab2_bin2bcd.sv | 48 ++++
 rtl/lab2_sseg_drv.sv | 180 ++++++++++++++++++
 tb/tb_lab2_sseg_drv.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_pkg.sv
// lab2_pkg: shared constants for the seven-segment driver.
// Glyphs are stored active-high (bit0 = segment a); the driver applies
// output polarity. The FSM enum is only used when LAB2_SSEG_BCD_EN is defined.
package lab2_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // All segments dark, active-high encoding.
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lab2_bin2bcd.sv
// lab2_bin2bcd: iterative 8-bit binary to 3-digit BCD (double dabble).
// i_start clears the accumulator; the next 8 edges each adjust (+3 on any
// nibble >= 5) and shift in one source bit, MSB first. i_bin must stay
// stable while busy. o_done is high during the cycle whose closing edge
// performs the last iteration; o_bcd is valid from the following cycle.
module lab2_bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic        o_done,
  output logic [11:0] o_bcd
);

  logic [11:0] r_bcd;
  logic [2:0]  r_it;
  logic        r_busy;
  logic [11:0] w_adj;

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    w_adj = r_bcd;
    if (r_bcd[3:0]  >= 4'd5) w_adj[3:0]  = r_bcd[3:0]  + 4'd3;
    if (r_bcd[7:4]  >= 4'd5) w_adj[7:4]  = r_bcd[7:4]  + 4'd3;
    if (r_bcd[11:8] >= 4'd5) w_adj[11:8] = r_bcd[11:8] + 4'd3;
  end

  // One shift/add-3 step per edge; a new start always restarts cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd  <= '0;
      r_it   <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bcd  <= '0;
      r_it   <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= {w_adj[10:0], i_bin[3'd7 - r_it]};
      r_it  <= r_it + 3'd1;
      if (r_it == 3'd7) r_busy <= 1'b0;
    end
  end

  assign o_done = r_busy && (r_it == 3'd7);
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/lab2_sseg_drv.sv
// lab2_sseg_drv: 4-digit multiplexed seven-segment driver for an 8-bit value.
// Build option LAB2_SSEG_BCD_EN: defined -> decimal display through the
// lab2_bin2bcd converter with leading-zero blanking and a load handshake;
// undefined -> two hex digits, ready tied high.
// seg/an are registered from the scan index and the digit register only, so
// d_in never reaches the pins combinationally and digits change atomically.
module lab2_sseg_drv
  import lab2_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_in,
  input  logic       load,
  output logic       ready,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam bit ACT_LOW = (SEG_ACTIVE_LOW != 0);

  logic [7:0]                 r_value;
  logic [CW-1:0]              r_cnt;
  logic [1:0]                 r_scan;
  logic [NUM_DIGITS-1:0][3:0] r_dig;
  logic [NUM_DIGITS-1:0]      r_lit;
  logic [6:0]                 r_seg;
  logic [3:0]                 r_an;

  logic                       w_accept;
  logic [3:0]                 w_cur_dig;
  logic                       w_cur_lit;
  logic [6:0]                 w_glyph;
  logic [3:0]                 w_onehot;

  assign w_accept = load & ready;

  // Value register: capture on accepted load only; loads while busy are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_value <= '0;
    else if (w_accept) r_value <= d_in;
  end

  // Refresh divider and scan index; scan advances once per counter wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_scan <= '0;
    end else if (r_cnt == CW'(REFRESH_DIV - 1)) begin
      r_cnt  <= '0;
      r_scan <= r_scan + 2'd1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

`ifdef LAB2_SSEG_BCD_EN

  state_t      r_state;
  logic        r_ready;
  logic        w_done;
  logic [11:0] w_bcd;

  assign ready = r_ready;

  // Converter reads the captured value, which cannot change while ready=0.
  lab2_bin2bcd u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept),
    .i_bin   (r_value),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // Load/convert/commit FSM; digit register only changes in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_dig   <= '0;
      r_lit   <= 4'b0001;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= CONV;
            r_ready <= 1'b0;
          end
        end
        CONV: begin
          if (w_done) r_state <= DONE;
        end
        DONE: begin
          r_dig   <= {4'h0, w_bcd[11:8], w_bcd[7:4], w_bcd[3:0]};
          // Ones always lit; tens lit unless both upper digits are zero.
          r_lit   <= {1'b0,
                      (w_bcd[11:8] != 4'h0),
                      (w_bcd[11:8] != 4'h0) || (w_bcd[7:4] != 4'h0),
                      1'b1};
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

`else

  logic r_upd;

  assign ready = 1'b1;

  // Hex digits follow the value register one edge after the capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_upd <= 1'b0;
      r_dig <= '0;
      r_lit <= 4'b0001;
    end else begin
      r_upd <= w_accept;
      if (r_upd) begin
        r_dig <= {8'h00, r_value};
        r_lit <= 4'b0011;
      end
    end
  end

`endif

  // Select the scanned digit and decode it to an active-high glyph.
  always_comb begin
    w_cur_dig = r_dig[r_scan];
    w_cur_lit = r_lit[r_scan];
    w_onehot  = 4'b0001 << r_scan;
    case (w_cur_dig)
      4'h0:    w_glyph = GLYPH_0;
      4'h1:    w_glyph = GLYPH_1;
      4'h2:    w_glyph = GLYPH_2;
      4'h3:    w_glyph = GLYPH_3;
      4'h4:    w_glyph = GLYPH_4;
      4'h5:    w_glyph = GLYPH_5;
      4'h6:    w_glyph = GLYPH_6;
      4'h7:    w_glyph = GLYPH_7;
      4'h8:    w_glyph = GLYPH_8;
      4'h9:    w_glyph = GLYPH_9;
      4'hA:    w_glyph = GLYPH_A;
      4'hB:    w_glyph = GLYPH_B;
      4'hC:    w_glyph = GLYPH_C;
      4'hD:    w_glyph = GLYPH_D;
      4'hE:    w_glyph = GLYPH_E;
      default: w_glyph = GLYPH_F;
    endcase
  end

  // Registered pin drivers with polarity applied; blanked digits go fully dark.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= ACT_LOW ? 4'hF : 4'h0;
      r_seg <= ACT_LOW ? ~SEG_OFF : SEG_OFF;
    end else if (w_cur_lit) begin
      r_an  <= ACT_LOW ? ~w_onehot : w_onehot;
      r_seg <= ACT_LOW ? ~w_glyph : w_glyph;
    end else begin
      r_an  <= ACT_LOW ? 4'hF : 4'h0;
      r_seg <= ACT_LOW ? ~SEG_OFF : SEG_OFF;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_lab2_sseg_drv.sv
// tb_lab2_sseg_drv: directed bench for lab2_sseg_drv (REFRESH_DIV=4,
// active-low pins). Covers hex or decimal build depending on LAB2_SSEG_BCD_EN.
module tb_lab2_sseg_drv;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       ready;
  logic [6:0] seg;
  logic [3:0] an;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  typedef struct packed {
    logic [3:0]      lit;
    logic [3:0][3:0] dig;
  } frame_t;

  frame_t exp_q[$];

  lab2_sseg_drv #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .load  (load),
    .ready (ready),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  // Edges since reset release; output after edge n reflects scan slot (n-1)/DIV.
  always @(posedge clk or negedge rst) begin
    if (!rst) ncyc <= 0;
    else      ncyc <= ncyc + 1;
  end

  // At most one digit enable active on any cycle.
  always @(negedge clk) begin
    total++;
    assert ($countones(~an) <= 1)
      else begin bad++; $error("FAIL glitch an=%b", an); end
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic frame_t model(input logic [7:0] v);
    frame_t f;
`ifdef LAB2_SSEG_BCD_EN
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    f.lit = {1'b0, (h != 0), (h != 0) || (t != 0), 1'b1};
    f.dig = {4'h0, 4'(h), 4'(t), 4'(o)};
`else
    f.lit = 4'b0011;
    f.dig = {8'h00, v};
`endif
    return f;
  endfunction

  function automatic frame_t reset_frame();
    frame_t f;
    f.lit = 4'b0001;
    f.dig = '0;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
      else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv); end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    d_in = v;
    load = 1'b1;
    exp_q.push_back(model(v));
    tick();
    load = 1'b0;
  endtask

  // Compare one full scan (4 slots) against the oldest expected frame.
  task automatic check_frame(input string tag);
    frame_t     f;
    int         s;
    logic [3:0] ea;
    logic [6:0] es;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=frame", tag);
      return;
    end
    f = exp_q.pop_front();
    for (int i = 0; i < 4 * DIV; i++) begin
      tick();
      s  = ((ncyc - 1) / DIV) % 4;
      ea = f.lit[s] ? ~(4'b0001 << s) : 4'hF;
      es = f.lit[s] ? ~glyph(f.dig[s]) : 7'h7F;
      chk({tag, "_an"}, 32'(an), 32'(ea));
      chk({tag, "_seg"}, 32'(seg), 32'(es));
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_ready", 32'(ready), 32'h1);

    rst = 1'b1;
    exp_q.push_back(reset_frame());
    check_frame("after_rst");

`ifdef LAB2_SSEG_BCD_EN
    // 255: ready low for 9 cycles, then 2/5/5.
    do_load(8'd255);
    chk("busy_k", 32'(ready), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("busy", 32'(ready), 32'h0);
    end
    tick();
    chk("ready_back", 32'(ready), 32'h1);
    tick();
    check_frame("dec255");

    // 7 then 200 during conversion: second load dropped.
    do_load(8'd7);
    tick();
    tick();
    d_in = 8'd200;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("ignored_ready", 32'(ready), 32'h0);
    repeat (7) tick();
    check_frame("dec7");

    // Reset before edge k+4 of a 99 conversion aborts it.
    do_load(8'd99);
    repeat (3) tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    tick();
    chk("abort_ready", 32'(ready), 32'h1);
    chk("abort_an", 32'(an), 32'hF);
    chk("abort_seg", 32'(seg), 32'h7F);
    tick();
    rst = 1'b1;
    exp_q.push_back(reset_frame());
    check_frame("abort_zero");
    do_load(8'd99);
    repeat (10) tick();
    check_frame("dec99");

    // Load on the first edge after reset release.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    do_load(8'd123);
    chk("first_edge_busy", 32'(ready), 32'h0);
    repeat (9) tick();
    check_frame("dec123");
`else
    do_load(8'hA7);
    chk("hex_ready", 32'(ready), 32'h1);
    tick();
    tick();
    check_frame("hexA7");

    // Back-to-back loads: the later value wins.
    d_in = 8'h12;
    load = 1'b1;
    tick();
    d_in = 8'h34;
    exp_q.push_back(model(8'h34));
    tick();
    load = 1'b0;
    tick();
    tick();
    check_frame("hex34");

    do_load(8'h00);
    tick();
    tick();
    check_frame("hex00");

    // Load on the first edge after reset release.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    do_load(8'h5C);
    tick();
    tick();
    check_frame("hex5C");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
